// File: rtl/micro_sequencer.sv
// rtl/micro_sequencer.sv - Mic-1 style control-store sequencer: MPC, control store, MIR and next-address logic.
module micro_sequencer #(
    parameter int CS_AW = 9,
    parameter int MIR_W = 36
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic             alu_n,
    input  logic             alu_z,
    input  logic [7:0]       mbr,
    input  logic             cs_we,
    input  logic [CS_AW-1:0] cs_waddr,
    input  logic [MIR_W-1:0] cs_wdata,
    output logic [8:0]       c_select,
    output logic [3:0]       b_select_encoded,
    output logic [5:0]       alu_ctrl,
    output logic [1:0]       shift_ctrl,
    output logic             mem_write,
    output logic             mem_read,
    output logic             mem_fetch,
    output logic [CS_AW-1:0] mpc,
    output logic             n_flag,
    output logic             z_flag
);

    logic [MIR_W-1:0] cs_mem [2**CS_AW];

    logic [MIR_W-1:0] mir_q;
    logic [CS_AW-1:0] mpc_q, mpc_d;
    logic             n_q, n_d;
    logic             z_q, z_d;
    logic [CS_AW-1:0] na;

    // JAM bits OR into bit 8; they never add, so 0x0FF with JAM stays in range.
    always_comb begin
        na[7:0] = mir_q[34:27] | (mir_q[26] ? mbr : 8'h00);
        na[8]   = mir_q[35] | (mir_q[25] & alu_n) | (mir_q[24] & alu_z);
    end

    always_comb begin
        mpc_d = mpc_q;
        n_d   = n_q;
        z_d   = z_q;
        if (!stall) begin
            mpc_d = na;
            n_d   = alu_n;
            z_d   = alu_z;
        end
    end

    always_ff @(posedge clock) begin
        if (cs_we) begin
            cs_mem[cs_waddr] <= cs_wdata;
        end
    end

    // Read uses the pre-edge array, so a same-address write lands one visit later.
    always_ff @(posedge clock) begin
        if (reset) begin
            mpc_q <= '0;
            mir_q <= '0;
            n_q   <= 1'b0;
            z_q   <= 1'b0;
        end else begin
            mpc_q <= mpc_d;
            n_q   <= n_d;
            z_q   <= z_d;
            if (!stall) begin
                mir_q <= cs_mem[na];
            end
        end
    end

    assign c_select                         = stall ? 9'h000 : mir_q[15:7];
    assign {mem_write, mem_read, mem_fetch} = stall ? 3'b000 : mir_q[6:4];
    assign b_select_encoded                 = mir_q[3:0];
    assign alu_ctrl                         = mir_q[21:16];
    assign shift_ctrl                       = mir_q[23:22];
    assign mpc                              = mpc_q;
    assign n_flag                           = n_q;
    assign z_flag                           = z_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// tb/tb_micro_sequencer.sv - directed bench for micro_sequencer with an abstract cycle model.
module tb_micro_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        alu_n = 1'b0;
    logic        alu_z = 1'b0;
    logic [7:0]  mbr = 8'h00;
    logic        cs_we = 1'b0;
    logic [8:0]  cs_waddr = 9'h000;
    logic [35:0] cs_wdata = 36'h0;

    logic [8:0]  c_select;
    logic [3:0]  b_select_encoded;
    logic [5:0]  alu_ctrl;
    logic [1:0]  shift_ctrl;
    logic        mem_write, mem_read, mem_fetch;
    logic [8:0]  mpc;
    logic        n_flag, z_flag;

    micro_sequencer dut (
        .clock(clock), .reset(reset), .stall(stall), .alu_n(alu_n), .alu_z(alu_z),
        .mbr(mbr), .cs_we(cs_we), .cs_waddr(cs_waddr), .cs_wdata(cs_wdata),
        .c_select(c_select), .b_select_encoded(b_select_encoded), .alu_ctrl(alu_ctrl),
        .shift_ctrl(shift_ctrl), .mem_write(mem_write), .mem_read(mem_read),
        .mem_fetch(mem_fetch), .mpc(mpc), .n_flag(n_flag), .z_flag(z_flag)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    longint cs_model [512];
    longint m_mir = 0;
    int     m_mpc = 0;
    int     m_n = 0;
    int     m_z = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int fld(input longint w, input int lsb, input int width);
        return int'((w / (64'd1 << lsb)) % (64'd1 << width));
    endfunction

    function automatic longint mk(input int na, input int jmpc, input int jamn, input int jamz,
                                  input int sh, input int alu, input int c, input int mem, input int b);
        return longint'(na) * 2**27 + longint'(jmpc) * 2**26 + longint'(jamn) * 2**25
             + longint'(jamz) * 2**24 + longint'(sh) * 2**22 + longint'(alu) * 2**16
             + longint'(c) * 2**7 + longint'(mem) * 2**4 + longint'(b);
    endfunction

    function automatic int next_addr(input longint w, input int n, input int z, input int op);
        int nf, low, hi;
        nf  = fld(w, 27, 9);
        low = (nf % 256) | (fld(w, 26, 1) != 0 ? op : 0);
        hi  = (nf >= 256 || (fld(w, 25, 1) != 0 && n != 0) || (fld(w, 24, 1) != 0 && z != 0)) ? 1 : 0;
        return hi * 256 + low;
    endfunction

    task automatic tick();
        int na;
        @(posedge clock);
        if (reset) begin
            m_mpc = 0; m_mir = 0; m_n = 0; m_z = 0;
        end else if (!stall) begin
            na    = next_addr(m_mir, int'(alu_n), int'(alu_z), int'(mbr));
            m_mpc = na;
            m_mir = cs_model[na];
            m_n   = int'(alu_n);
            m_z   = int'(alu_z);
        end
        if (cs_we) cs_model[int'(cs_waddr)] = longint'(cs_wdata);
        chk_en = 1'b1;
        #1;
    endtask

    task automatic wr(input int a, input longint d);
        cs_we    = 1'b1;
        cs_waddr = 9'(a);
        cs_wdata = 36'(d);
        tick();
        cs_we    = 1'b0;
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            chk("mpc", int'(mpc), m_mpc);
            chk("c_select", int'(c_select), stall ? 0 : fld(m_mir, 7, 9));
            chk("mem_strobes", int'({mem_write, mem_read, mem_fetch}), stall ? 0 : fld(m_mir, 4, 3));
            chk("b_select", int'(b_select_encoded), fld(m_mir, 0, 4));
            chk("alu_ctrl", int'(alu_ctrl), fld(m_mir, 16, 6));
            chk("shift_ctrl", int'(shift_ctrl), fld(m_mir, 22, 2));
            chk("n_flag", int'(n_flag), m_n);
            chk("z_flag", int'(z_flag), m_z);
        end
    end

    initial begin
        for (int i = 0; i < 512; i++) cs_model[i] = 0;
        alu_n = 1'b1;
        alu_z = 1'b1;
        stall = 1'b1;
        wr(9'h000, mk(9'h005, 0, 0, 0, 0, 0, 9'h100, 0, 1));
        chk("rst_mpc", int'(mpc), 0);
        chk("rst_c", int'(c_select), 0);
        chk("rst_flags", int'({n_flag, z_flag}), 0);
        stall = 1'b0;
        wr(9'h005, mk(9'h005, 0, 0, 0, 0, 0, 0, 0, 0));
        wr(9'h010, mk(9'h000, 1, 0, 0, 0, 0, 0, 0, 0));
        wr(9'h060, mk(9'h100, 1, 0, 0, 0, 0, 0, 0, 0));
        wr(9'h160, mk(9'h020, 0, 0, 0, 0, 0, 0, 0, 0));
        wr(9'h020, mk(9'h012, 0, 0, 1, 0, 0, 0, 0, 0));
        wr(9'h112, mk(9'h020, 0, 0, 0, 0, 0, 0, 0, 0));
        wr(9'h012, mk(9'h030, 0, 0, 0, 0, 0, 0, 0, 0));
        wr(9'h030, mk(9'h013, 0, 1, 0, 0, 0, 0, 0, 0));
        wr(9'h113, mk(9'h030, 0, 0, 0, 0, 0, 0, 0, 0));
        wr(9'h013, mk(9'h040, 0, 0, 0, 0, 0, 9'h003, 2, 0));
        wr(9'h040, mk(9'h1FF, 0, 0, 0, 0, 0, 9'h1FF, 0, 4));
        wr(9'h1FF, mk(9'h17F, 0, 1, 1, 0, 0, 0, 0, 0));
        wr(9'h17F, mk(9'h042, 0, 0, 0, 0, 0, 0, 0, 0));
        wr(9'h042, mk(9'h042, 0, 0, 0, 3, 6'h3C, 9'h080, 7, 7));

        reset = 1'b0;
        alu_n = 1'b0;
        alu_z = 1'b0;
        tick();
        chk("c1_mpc", int'(mpc), 0);
        chk("c1_c", int'(c_select), 9'h100);
        chk("c1_b", int'(b_select_encoded), 1);
        tick();
        chk("c2_mpc", int'(mpc), 5);
        chk("c2_c", int'(c_select), 0);
        tick();

        wr(9'h005, mk(9'h010, 0, 0, 0, 0, 0, 9'h0F0, 0, 2));
        chk("coll_old_c", int'(c_select), 0);
        tick();
        chk("coll_new_c", int'(c_select), 9'h0F0);
        chk("coll_new_b", int'(b_select_encoded), 2);
        mbr = 8'h60;
        tick();
        chk("to_jmpc", int'(mpc), 9'h010);
        tick();
        chk("jmpc_lo", int'(mpc), 9'h060);
        tick();
        chk("jmpc_hi", int'(mpc), 9'h160);
        mbr = 8'h00;
        tick();
        chk("to_jamz", int'(mpc), 9'h020);

        alu_z = 1'b1;
        tick();
        chk("jamz_taken", int'(mpc), 9'h112);
        chk("jamz_zflag", int'(z_flag), 1);
        alu_z = 1'b0;
        tick();
        tick();
        chk("jamz_not", int'(mpc), 9'h012);
        chk("jamz_zclr", int'(z_flag), 0);
        tick();
        alu_n = 1'b1;
        tick();
        chk("jamn_taken", int'(mpc), 9'h113);
        chk("jamn_nflag", int'(n_flag), 1);
        alu_n = 1'b0;
        tick();
        tick();
        chk("jamn_not", int'(mpc), 9'h013);

        stall = 1'b1;
        #1;
        chk("stall_c", int'(c_select), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_mpc", int'(mpc), 9'h013);
            chk("stall_rd", int'(mem_read), 0);
        end
        stall = 1'b0;
        #1;
        chk("unstall_c", int'(c_select), 9'h003);
        chk("unstall_rd", int'(mem_read), 1);
        tick();
        chk("adv_mpc", int'(mpc), 9'h040);
        tick();
        chk("na_1ff", int'(mpc), 9'h1FF);
        alu_n = 1'b1;
        alu_z = 1'b1;
        tick();
        chk("jam_both", int'(mpc), 9'h17F);
        alu_n = 1'b0;
        alu_z = 1'b0;
        tick();
        chk("at_42", int'(mpc), 9'h042);
        chk("at_42_strobes", int'({mem_write, mem_read, mem_fetch}), 7);

        reset = 1'b1;
        stall = 1'b1;
        tick();
        chk("midrst_mpc", int'(mpc), 0);
        chk("midrst_c", int'(c_select), 0);
        chk("midrst_alu", int'(alu_ctrl), 0);
        reset = 1'b0;
        stall = 1'b0;
        tick();
        chk("rerun_c", int'(c_select), 9'h100);
        tick();
        chk("rerun_mpc", int'(mpc), 5);
        chk("rerun_c5", int'(c_select), 9'h0F0);
        @(negedge clock);
        chk_en = 1'b0;
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
